// File: rtl/quan_bias_add_pipe.sv
// Elastic two-stage per-channel bias adder between the quant multiplier and requantise stage.
// Define QPAB_SAT_EN to clamp each lane to OUT_W bits in stage 2 and drive a sticky sat_flag.
module quan_bias_add_pipe #(
    parameter int NCH    = 2,
    parameter int LPC    = 32,
    parameter int P_W    = 40,
    parameter int BIAS_W = 8,
    parameter int OUT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [NCH*LPC*P_W-1:0]   sum_mult_E,
    input  logic                     bias_wr_en,
    input  logic [NCH*BIAS_W-1:0]    bias_wr_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [NCH*LPC*P_W-1:0]   out_vec,
    output logic                     sat_flag
);

    localparam int NL = NCH * LPC;
    localparam int VW = NL * P_W;
    localparam int BW = NCH * BIAS_W;

    if (OUT_W > P_W) begin : g_bad_cfg
        $error("OUT_W must not exceed P_W");
    end

    logic          s1_valid, s2_valid;
    logic          s1_last, s2_last;
    logic [VW-1:0] s1_vec, s2_vec;
    logic [VW-1:0] s1_nxt, s2_nxt;
    logic [BW-1:0] shadow_bias, active_bias;
    logic          s1_adv, s2_adv, accept;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    for (genvar i = 0; i < NL; i++) begin : g_add
        localparam int C  = i / LPC;
        localparam bit LO = (i < LPC);
        logic [P_W-1:0] lane, b0_ext, bc_ext, sum;

        assign lane   = sum_mult_E[i*P_W +: P_W];
        assign b0_ext = {{(P_W-BIAS_W){active_bias[BIAS_W-1]}},
                         active_bias[BIAS_W-1:0]};
        assign bc_ext = {{(P_W-BIAS_W){active_bias[C*BIAS_W+BIAS_W-1]}},
                         active_bias[C*BIAS_W +: BIAS_W]};

        always_comb begin
            sum = '0;
            case (mode)
                4'd0:    sum = LO ? lane + b0_ext : '0;
                4'd1:    sum = lane + bc_ext;
                default: sum = '0;
            endcase
        end

        assign s1_nxt[i*P_W +: P_W] = sum;
    end

`ifdef QPAB_SAT_EN
    logic [NL-1:0] lane_sat;
    logic          sat_q;

    for (genvar i = 0; i < NL; i++) begin : g_sat
        logic [P_W-1:0]     v;
        logic [P_W-OUT_W:0] hi;

        assign v           = s1_vec[i*P_W +: P_W];
        assign hi          = v[P_W-1:OUT_W-1];
        // In range only when every bit above the OUT_W sign bit matches it
        assign lane_sat[i] = !((&hi) || !(|hi));
        assign s2_nxt[i*P_W +: P_W] =
            !lane_sat[i] ? v :
            v[P_W-1]     ? {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}} :
                           {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sat_q <= 1'b0;
        else if (s1_valid && s2_adv && (|lane_sat))
            sat_q <= 1'b1;
    end

    assign sat_flag = sat_q;
`else
    assign s2_nxt   = s1_vec;
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_bias <= '0;
            active_bias <= '0;
            s1_valid    <= 1'b0;
            s1_last     <= 1'b0;
            s1_vec      <= '0;
            s2_valid    <= 1'b0;
            s2_last     <= 1'b0;
            s2_vec      <= '0;
        end else begin
            if (bias_wr_en)
                shadow_bias <= bias_wr_data;
            // The last beat already captured its sum with the old bank
            if (accept && in_last)
                active_bias <= shadow_bias;
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_vec  <= s1_nxt;
                    s1_last <= in_last;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_vec  <= s2_nxt;
                    s2_last <= s1_last;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_last  = s2_last;
    assign out_vec   = s2_vec;

endmodule

// File: tb/tb_quan_bias_add_pipe.sv
// Directed bench for quan_bias_add_pipe: reset, modes, backpressure, bias swap, saturation.
// Expected lanes are hand-computed; QPAB_SAT_EN selects the clamp or wrap expectation.
module tb_quan_bias_add_pipe;

    localparam int NCH    = 2;
    localparam int LPC    = 32;
    localparam int P_W    = 40;
    localparam int BIAS_W = 8;
    localparam int NL     = NCH * LPC;
    localparam int VW     = NL * P_W;

    logic                   clk;
    logic                   reset;
    logic [3:0]             mode;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [VW-1:0]          sum_mult_E;
    logic                   bias_wr_en;
    logic [NCH*BIAS_W-1:0]  bias_wr_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic [VW-1:0]          out_vec;
    logic                   sat_flag;

    int            total;
    int            passed;
    int            k;
    logic [VW-1:0] expv;

    quan_bias_add_pipe #(
        .NCH(NCH), .LPC(LPC), .P_W(P_W), .BIAS_W(BIAS_W), .OUT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .sum_mult_E(sum_mult_E),
        .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .out_vec(out_vec), .sat_flag(sat_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [VW-1:0] mk(input longint v0, input longint v1);
        logic [VW-1:0]  r;
        logic [P_W-1:0] a, b;
        a = v0[P_W-1:0];
        b = v1[P_W-1:0];
        for (int i = 0; i < NL; i++)
            r[i*P_W +: P_W] = (i < LPC) ? a : b;
        return r;
    endfunction

    function automatic int first_diff(input logic [VW-1:0] a, input logic [VW-1:0] b);
        for (int i = 0; i < NL; i++)
            if (a[i*P_W +: P_W] !== b[i*P_W +: P_W]) return i;
        return 0;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_bias(input logic [7:0] b1, input logic [7:0] b0);
        bias_wr_en   = 1'b1;
        bias_wr_data = {b1, b0};
        tick();
        bias_wr_en = 1'b0;
        in_valid   = 1'b1;
        mode       = 4'd2;
        in_last    = 1'b1;
        sum_mult_E = '0;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic send_one(input logic [3:0] m, input logic [VW-1:0] v, input logic last);
        mode       = m;
        sum_mult_E = v;
        in_last    = last;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #12;
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid);
        else passed++;
        total++;
        if (out_vec !== '0) $display("FAIL rst_vec got %h want 0", out_vec[P_W-1:0]);
        else passed++;
        total++;
        if (out_last !== 1'b0 || sat_flag !== 1'b0)
            $display("FAIL rst_flags got %b%b want 00", out_last, sat_flag);
        else passed++;
        reset = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", in_ready);
        else passed++;
        // fill both stages with the output stalled, then reset mid-stream
        out_ready  = 1'b0;
        mode       = 4'd1;
        sum_mult_E = mk(100, 100);
        in_valid   = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL full_stall got v%b r%b want v1 r0", out_valid, in_ready);
        else passed++;
        #2 reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid);
        else passed++;
        total++;
        if (out_vec !== '0) $display("FAIL midrst_vec got %h want 0", out_vec[P_W-1:0]);
        else passed++;
        #1 reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", in_ready);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL midrst_drop got %b want 0", out_valid);
        else passed++;
        out_ready = 1'b1;
    endtask

    task automatic test_mode1;
        set_bias(8'hFD, 8'h05);
        mode       = 4'd1;
        sum_mult_E = mk(100, 100);
        in_last    = 1'b0;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL t2_lat1 got %b want 0", out_valid);
        else passed++;
        tick();
        total++;
        if (out_valid !== 1'b1) $display("FAIL t2_lat2 got %b want 1", out_valid);
        else passed++;
        expv = mk(105, 97);
        total++;
        if (out_vec !== expv) begin
            k = first_diff(out_vec, expv);
            $display("FAIL t2_vec lane %0d got %h want %h", k,
                     out_vec[k*P_W +: P_W], expv[k*P_W +: P_W]);
        end else passed++;
        tick();
        total++;
        if (out_valid !== 1'b0) $display("FAIL t2_dup got %b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_mode0_mode3;
        set_bias(8'h00, 8'h80);
        send_one(4'd0, mk(0, 0), 1'b0);
        expv = mk(-128, 0);
        total++;
        if (out_valid !== 1'b1 || out_vec !== expv) begin
            k = first_diff(out_vec, expv);
            $display("FAIL t3_m0 v%b lane %0d got %h want %h", out_valid, k,
                     out_vec[k*P_W +: P_W], expv[k*P_W +: P_W]);
        end else passed++;
        send_one(4'd0, mk(200, 300), 1'b0);
        expv = mk(72, 0);
        total++;
        if (out_vec !== expv) begin
            k = first_diff(out_vec, expv);
            $display("FAIL t3_m0_hi lane %0d got %h want %h", k,
                     out_vec[k*P_W +: P_W], expv[k*P_W +: P_W]);
        end else passed++;
        send_one(4'd3, mk(55, 66), 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_vec !== '0) begin
            k = first_diff(out_vec, '0);
            $display("FAIL t3_m3 v%b lane %0d got %h want 0", out_valid, k,
                     out_vec[k*P_W +: P_W]);
        end else passed++;
        total++;
        if (out_last !== 1'b1) $display("FAIL t3_last got %b want 1", out_last);
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back;
        int   sent, got, infl, cyc;
        logic acc, fire, exp_rdy;
        sent = 0; got = 0; infl = 0; cyc = 0;
        set_bias(8'd2, 8'd1);
        while (got < 10 && cyc < 200) begin
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 10) begin
                in_valid   = 1'b1;
                mode       = 4'd1;
                sum_mult_E = mk(sent * 10, sent * 10 + 1);
                in_last    = (sent == 9);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            #1;
            exp_rdy = !(infl == 2 && !out_ready);
            total++;
            if (in_ready !== exp_rdy)
                $display("FAIL t4_ready cyc %0d got %b want %b", cyc, in_ready, exp_rdy);
            else passed++;
            acc  = in_valid && in_ready;
            fire = out_valid && out_ready;
            if (fire) begin
                expv = mk(got * 10 + 1, got * 10 + 3);
                total++;
                if (out_vec !== expv || out_last !== (got == 9)) begin
                    k = first_diff(out_vec, expv);
                    $display("FAIL t4_beat %0d last %b lane %0d got %h want %h", got,
                             out_last, k, out_vec[k*P_W +: P_W], expv[k*P_W +: P_W]);
                end else passed++;
                got++;
            end
            if (acc) sent++;
            infl = infl + int'(acc) - int'(fire);
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++;
        if (got !== 10) $display("FAIL t4_count got %0d want 10", got);
        else passed++;
        out_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_swap;
        out_ready    = 1'b1;
        bias_wr_en   = 1'b1;
        bias_wr_data = {8'd0, 8'd7};
        tick();
        bias_wr_en = 1'b0;
        mode       = 4'd0;
        sum_mult_E = mk(10, 10);
        in_last    = 1'b1;
        in_valid   = 1'b1;
        tick();
        sum_mult_E = mk(20, 20);
        in_last    = 1'b0;
        tick();
        in_valid = 1'b0;
        expv = mk(11, 0);
        total++;
        if (out_vec !== expv || out_last !== 1'b1)
            $display("FAIL t5_a last %b got %h want %h", out_last,
                     out_vec[P_W-1:0], expv[P_W-1:0]);
        else passed++;
        tick();
        expv = mk(27, 0);
        total++;
        if (out_valid !== 1'b1 || out_vec !== expv)
            $display("FAIL t5_b v%b got %h want %h", out_valid,
                     out_vec[P_W-1:0], expv[P_W-1:0]);
        else passed++;
        // bias write and tile end in the same cycle
        bias_wr_en   = 1'b1;
        bias_wr_data = {8'd0, 8'd9};
        sum_mult_E   = mk(30, 30);
        in_last      = 1'b1;
        in_valid     = 1'b1;
        tick();
        bias_wr_en = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        tick();
        expv = mk(37, 0);
        total++;
        if (out_vec !== expv)
            $display("FAIL t5_c got %h want %h", out_vec[P_W-1:0], expv[P_W-1:0]);
        else passed++;
        send_one(4'd0, mk(40, 40), 1'b1);
        expv = mk(47, 0);
        total++;
        if (out_vec !== expv)
            $display("FAIL t5_d got %h want %h", out_vec[P_W-1:0], expv[P_W-1:0]);
        else passed++;
        send_one(4'd0, mk(50, 50), 1'b0);
        expv = mk(59, 0);
        total++;
        if (out_vec !== expv)
            $display("FAIL t5_e got %h want %h", out_vec[P_W-1:0], expv[P_W-1:0]);
        else passed++;
        tick();
    endtask

    task automatic test_sat;
        logic want_flag;
        set_bias(8'd0, 8'd1);
        total++;
        if (sat_flag !== 1'b0) $display("FAIL t6_pre got %b want 0", sat_flag);
        else passed++;
        send_one(4'd0, mk(64'h7FFF_FFFF, 5), 1'b0);
`ifdef QPAB_SAT_EN
        expv      = mk(64'h7FFF_FFFF, 0);
        want_flag = 1'b1;
`else
        expv      = mk(64'h8000_0000, 0);
        want_flag = 1'b0;
`endif
        total++;
        if (out_vec !== expv) begin
            k = first_diff(out_vec, expv);
            $display("FAIL t6_vec lane %0d got %h want %h", k,
                     out_vec[k*P_W +: P_W], expv[k*P_W +: P_W]);
        end else passed++;
        tick();
        total++;
        if (sat_flag !== want_flag)
            $display("FAIL t6_flag got %b want %b", sat_flag, want_flag);
        else passed++;
    endtask

    initial begin
        total        = 0;
        passed       = 0;
        reset        = 1'b1;
        mode         = '0;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        sum_mult_E   = '0;
        bias_wr_en   = 1'b0;
        bias_wr_data = '0;
        out_ready    = 1'b1;
        test_reset();
        test_mode1();
        test_mode0_mode3();
        test_back_to_back();
        test_swap();
        test_sat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
